axi4_lite_reg_slave: RTL and testbench

//  AXI4-Lite slave endpoint: a register bank of NUM_REGS words that consumes the master-driven
//  AW/W/AR channels and produces B/R responses. Sits downstream of any axi4_lite master (slave

---
 rtl/axi4_lite_reg_slave_if.sv | 45 ++++
 rtl/axi4_lite_reg_slave.sv | 155 +++++++++++++++
 tb/tb_axi4_lite_reg_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_reg_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_slave_if
// Brief    : AXI4-Lite AW/W/B/AR/R channel bundle with master/slave views
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_reg_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = (DATA_WIDTH == 32) ? 32 : 64
) ();
  localparam int c_STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic [2:0]            AWPROT;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [c_STRB_W-1:0]   WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic [2:0]            ARPROT;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARVALID, ARPROT, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARVALID, ARPROT, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_slave
// Brief    : AXI4-Lite register bank slave with per-register write strobes
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  wire logic                         aclk,
  input  wire logic                         aresetn,
  axi4_lite_reg_slave_if.slave              s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0]    regs_q,
  output logic [NUM_REGS-1:0]               wr_pulse
);
  localparam int c_ADDR_W   = (DATA_WIDTH == 32) ? 32 : 64;
  localparam int c_STRB_W   = DATA_WIDTH / 8;
  localparam int c_OFF_BITS = $clog2(c_STRB_W);
  localparam int c_IDX_BITS = $clog2(NUM_REGS);
  localparam logic [NUM_REGS-1:0] c_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

  wr_state_t               r_wr_state, w_wr_state_nxt;
  rd_state_t               r_rd_state, w_rd_state_nxt;
  logic                    r_rdy_en;
  logic                    r_aw_held, r_w_held;
  logic [c_ADDR_W-1:0]     r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_STRB_W-1:0]     r_wstrb;
  logic [1:0]              r_bresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic [NUM_REGS-1:0]     r_wr_pulse;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

  logic                    w_awready, w_wready, w_arready;
  logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [c_ADDR_W-1:0]     w_waddr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [c_STRB_W-1:0]     w_wstrb;
  logic [c_IDX_BITS-1:0]   w_widx, w_ridx;
  logic                    w_werr, w_rerr;
  logic                    w_unused;

  // Readies stay low until the first clock after reset release.
  always_comb begin
    w_awready      = r_rdy_en && (r_wr_state == WR_IDLE) && !r_aw_held;
    w_wready       = r_rdy_en && (r_wr_state == WR_IDLE) && !r_w_held;
    w_aw_hs        = s_axi.AWVALID && w_awready;
    w_w_hs         = s_axi.WVALID && w_wready;
    w_commit       = (r_wr_state == WR_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (w_commit)     w_wr_state_nxt = WR_RESP;
      WR_RESP: if (s_axi.BREADY) w_wr_state_nxt = WR_IDLE;
      default:                   w_wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    w_arready      = r_rdy_en && (r_rd_state == RD_IDLE);
    w_ar_hs        = s_axi.ARVALID && w_arready;
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_ar_hs)      w_rd_state_nxt = RD_DATA;
      RD_DATA: if (s_axi.RREADY) w_rd_state_nxt = RD_IDLE;
      default:                   w_rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state <= WR_IDLE;
      r_rd_state <= RD_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // A channel arriving on the commit edge bypasses its latch.
  assign w_waddr = r_aw_held ? r_awaddr : s_axi.AWADDR;
  assign w_wdata = r_w_held  ? r_wdata  : s_axi.WDATA;
  assign w_wstrb = r_w_held  ? r_wstrb  : s_axi.WSTRB;
  assign w_widx  = w_waddr[c_OFF_BITS +: c_IDX_BITS];
  assign w_werr  = |(w_waddr >> (c_OFF_BITS + c_IDX_BITS));
  assign w_ridx  = s_axi.ARADDR[c_OFF_BITS +: c_IDX_BITS];
  assign w_rerr  = |(s_axi.ARADDR >> (c_OFF_BITS + c_IDX_BITS));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdy_en   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= 2'b00;
      r_rdata    <= '0;
      r_rresp    <= 2'b00;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      r_rdy_en   <= 1'b1;
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= w_werr ? 2'b10 : 2'b00;
        if (!w_werr) begin
          for (int b = 0; b < c_STRB_W; b++)
            if (w_wstrb[b]) r_regs[w_widx][b*8 +: 8] <= w_wdata[b*8 +: 8];
          r_wr_pulse <= c_ONE << w_widx;
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_axi.AWADDR;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_axi.WDATA;
          r_wstrb  <= s_axi.WSTRB;
        end
      end
      if (w_ar_hs) begin
        r_rdata <= w_rerr ? '0 : r_regs[w_ridx];
        r_rresp <= w_rerr ? 2'b10 : 2'b00;
      end
    end
  end

  assign s_axi.AWREADY = w_awready;
  assign s_axi.WREADY  = w_wready;
  assign s_axi.BVALID  = (r_wr_state == WR_RESP);
  assign s_axi.BRESP   = r_bresp;
  assign s_axi.ARREADY = w_arready;
  assign s_axi.RVALID  = (r_rd_state == RD_DATA);
  assign s_axi.RDATA   = r_rdata;
  assign s_axi.RRESP   = r_rresp;
  assign wr_pulse      = r_wr_pulse;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_q
      assign regs_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end
  endgenerate

  assign w_unused = ^{s_axi.AWPROT, s_axi.ARPROT, w_waddr[c_OFF_BITS-1:0], s_axi.ARADDR[c_OFF_BITS-1:0]};
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_reg_slave
// Brief    : Directed vector bench for the AXI4-Lite register slave
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_reg_slave;
  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [255:0] regs_q;
  logic [7:0]   wr_pulse;
  int           n_pass = 0;
  int           n_total = 0;

  always #5 aclk = ~aclk;

  axi4_lite_reg_slave_if #(.DATA_WIDTH(32)) bus ();

  axi4_lite_reg_slave #(.DATA_WIDTH(32), .NUM_REGS(8), .RESET_VAL(32'h0)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_axi    (bus),
    .regs_q   (regs_q),
    .wr_pulse (wr_pulse)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic        chk_pulse;
    logic [7:0]  pulse;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ridx;
    logic [31:0] rval;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return regs_q[i*32 +: 32];
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    bus.AWADDR = addr; bus.AWVALID = 1'b1;
    bus.WDATA = data;  bus.WSTRB = strb; bus.WVALID = 1'b1;
    while (!(bus.AWREADY && bus.WREADY) && n < 20) begin tick; n++; end
    if (n >= 20) chk("aw_w_ready_timeout", {63'd0, bus.AWREADY && bus.WREADY}, 64'd1);
    tick;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
  endtask

  task automatic b_ack;
    bus.BREADY = 1'b1;
    tick;
    bus.BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    bus.ARADDR = addr; bus.ARVALID = 1'b1;
    while (!bus.ARREADY && n < 20) begin tick; n++; end
    if (n >= 20) chk("ar_ready_timeout", {63'd0, bus.ARREADY}, 64'd1);
    tick;
    bus.ARVALID = 1'b0;
    chk("rd_rvalid", {63'd0, bus.RVALID}, 64'd1);
    data = bus.RDATA; resp = bus.RRESP;
    bus.RREADY = 1'b1;
    tick;
    bus.RREADY = 1'b0;
    chk("rd_rvalid_clr", {63'd0, bus.RVALID}, 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;

    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.AWPROT = 3'b0;
    bus.WDATA = '0;  bus.WSTRB = '0;     bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.ARPROT = 3'b0; bus.RREADY = 1'b0;

    //            addr          wdata         strb   bresp  chkp  pulse  rdata         rresp  ridx rval
    vecs[0] = '{32'h0000_0004, 32'hDEADBEEF, 4'hF, 2'b00, 1'b1, 8'h02, 32'hDEADBEEF, 2'b00, 1, 32'hDEADBEEF};
    vecs[1] = '{32'h0000_0000, 32'hA5A5A5A5, 4'hF, 2'b00, 1'b1, 8'h01, 32'hA5A5A5A5, 2'b00, 0, 32'hA5A5A5A5};
    vecs[2] = '{32'h0000_001C, 32'h12345678, 4'hC, 2'b00, 1'b1, 8'h80, 32'h12340000, 2'b00, 7, 32'h12340000};
    vecs[3] = '{32'h0000_001F, 32'hFFFFFFFF, 4'h1, 2'b00, 1'b1, 8'h80, 32'h123400FF, 2'b00, 7, 32'h123400FF};
    vecs[4] = '{32'h0000_0020, 32'h0BADF00D, 4'hF, 2'b10, 1'b1, 8'h00, 32'h00000000, 2'b10, 0, 32'hA5A5A5A5};
    vecs[5] = '{32'h0000_0014, 32'hCAFEF00D, 4'h0, 2'b00, 1'b0, 8'h00, 32'h00000000, 2'b00, 5, 32'h00000000};
    vecs[6] = '{32'hFFFF_FFF0, 32'h00000001, 4'hF, 2'b10, 1'b1, 8'h00, 32'h00000000, 2'b10, 4, 32'h00000000};
    vecs[7] = '{32'h0000_0018, 32'h0000AB00, 4'h2, 2'b00, 1'b1, 8'h40, 32'h0000AB00, 2'b00, 6, 32'h0000AB00};

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_awready", {63'd0, bus.AWREADY}, 64'd0);
    chk("rst_arready", {63'd0, bus.ARREADY}, 64'd0);
    chk("rst_bvalid",  {63'd0, bus.BVALID}, 64'd0);
    chk("rst_rvalid",  {63'd0, bus.RVALID}, 64'd0);
    chk("rst_pulse",   {56'd0, wr_pulse}, 64'd0);
    chk("rst_regs",    {63'd0, |regs_q}, 64'd0);
    aresetn = 1'b1;
    tick;
    chk("rel_awready", {63'd0, bus.AWREADY}, 64'd1);
    chk("rel_wready",  {63'd0, bus.WREADY}, 64'd1);
    chk("rel_arready", {63'd0, bus.ARREADY}, 64'd1);
    chk("rel_rdata",   {32'd0, bus.RDATA}, 64'd0);

    // Vector table: write, response, strobe, read-back
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      chk($sformatf("v%0d_bvalid", i), {63'd0, bus.BVALID}, 64'd1);
      chk($sformatf("v%0d_bresp", i), {62'd0, bus.BRESP}, {62'd0, vecs[i].bresp});
      if (vecs[i].chk_pulse) chk($sformatf("v%0d_pulse", i), {56'd0, wr_pulse}, {56'd0, vecs[i].pulse});
      b_ack;
      chk($sformatf("v%0d_bvalid_clr", i), {63'd0, bus.BVALID}, 64'd0);
      chk($sformatf("v%0d_pulse_clr", i), {56'd0, wr_pulse}, 64'd0);
      do_read(vecs[i].addr, rd, rr);
      chk($sformatf("v%0d_rdata", i), {32'd0, rd}, {32'd0, vecs[i].rdata});
      chk($sformatf("v%0d_rresp", i), {62'd0, rr}, {62'd0, vecs[i].rresp});
      chk($sformatf("v%0d_reg", i), {32'd0, reg_of(vecs[i].ridx)}, {32'd0, vecs[i].rval});
    end

    // W three cycles ahead of AW
    bus.WDATA = 32'h11223344; bus.WSTRB = 4'b0101; bus.WVALID = 1'b1;
    tick;
    bus.WVALID = 1'b0;
    chk("wfirst_wready", {63'd0, bus.WREADY}, 64'd0);
    chk("wfirst_awready", {63'd0, bus.AWREADY}, 64'd1);
    tick; tick;
    chk("wfirst_bvalid_wait", {63'd0, bus.BVALID}, 64'd0);
    bus.AWADDR = 32'h8; bus.AWVALID = 1'b1;
    tick;
    bus.AWVALID = 1'b0;
    chk("wfirst_bvalid", {63'd0, bus.BVALID}, 64'd1);
    chk("wfirst_bresp", {62'd0, bus.BRESP}, 64'd0);
    chk("wfirst_pulse", {56'd0, wr_pulse}, 64'h04);
    chk("wfirst_reg2", {32'd0, reg_of(2)}, 64'h00220044);
    b_ack;

    // Read with RREADY held off
    bus.ARADDR = 32'h4; bus.ARVALID = 1'b1;
    chk("rstall_arready_pre", {63'd0, bus.ARREADY}, 64'd1);
    tick;
    bus.ARVALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rstall_rvalid_%0d", k), {63'd0, bus.RVALID}, 64'd1);
      chk($sformatf("rstall_rdata_%0d", k), {32'd0, bus.RDATA}, 64'hDEADBEEF);
      chk($sformatf("rstall_rresp_%0d", k), {62'd0, bus.RRESP}, 64'd0);
      chk($sformatf("rstall_arready_%0d", k), {63'd0, bus.ARREADY}, 64'd0);
      tick;
    end
    bus.RREADY = 1'b1;
    tick;
    bus.RREADY = 1'b0;
    chk("rstall_rvalid_clr", {63'd0, bus.RVALID}, 64'd0);
    chk("rstall_arready_post", {63'd0, bus.ARREADY}, 64'd1);

    // Back-pressured B stalls a second write
    do_write(32'h0, 32'h11111111, 4'hF);
    bus.AWADDR = 32'h0; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h22222222; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bstall_awready_%0d", k), {63'd0, bus.AWREADY}, 64'd0);
      chk($sformatf("bstall_wready_%0d", k), {63'd0, bus.WREADY}, 64'd0);
      chk($sformatf("bstall_bvalid_%0d", k), {63'd0, bus.BVALID}, 64'd1);
      tick;
    end
    chk("bstall_reg0_first", {32'd0, reg_of(0)}, 64'h11111111);
    bus.BREADY = 1'b1;
    tick;
    bus.BREADY = 1'b0;
    chk("bstall_bvalid_gap", {63'd0, bus.BVALID}, 64'd0);
    chk("bstall_awready_back", {63'd0, bus.AWREADY}, 64'd1);
    chk("bstall_reg0_hold", {32'd0, reg_of(0)}, 64'h11111111);
    tick;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("bstall_bvalid2", {63'd0, bus.BVALID}, 64'd1);
    chk("bstall_reg0_second", {32'd0, reg_of(0)}, 64'h22222222);
    chk("bstall_pulse2", {56'd0, wr_pulse}, 64'h01);
    b_ack;

    // Read and write to the same register on the same edge
    bus.AWADDR = 32'hC; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h00000077; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 32'hC; bus.ARVALID = 1'b1;
    tick;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    chk("same_rvalid", {63'd0, bus.RVALID}, 64'd1);
    chk("same_rdata_old", {32'd0, bus.RDATA}, 64'd0);
    chk("same_reg3_new", {32'd0, reg_of(3)}, 64'h77);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    tick;
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;

    // Reset with AW latched and W still pending
    bus.AWADDR = 32'h4; bus.AWVALID = 1'b1;
    tick;
    bus.AWVALID = 1'b0;
    chk("mrst_aw_held", {63'd0, bus.AWREADY}, 64'd0);
    chk("mrst_w_open", {63'd0, bus.WREADY}, 64'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("mrst_regs", {63'd0, |regs_q}, 64'd0);
    chk("mrst_bvalid", {63'd0, bus.BVALID}, 64'd0);
    chk("mrst_awready", {63'd0, bus.AWREADY}, 64'd0);
    chk("mrst_pulse", {56'd0, wr_pulse}, 64'd0);
    tick; tick;
    aresetn = 1'b1;
    tick;
    chk("mrst_awready_rel", {63'd0, bus.AWREADY}, 64'd1);
    bus.WDATA = 32'hFFFFFFFF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick;
    bus.WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mrst_w_only_bvalid_%0d", k), {63'd0, bus.BVALID}, 64'd0);
      chk($sformatf("mrst_w_only_wready_%0d", k), {63'd0, bus.WREADY}, 64'd0);
      tick;
    end
    chk("mrst_reg1", {32'd0, reg_of(1)}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
